// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | game_pkg : shared types and constants for the score keeper.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int NUM_LANES   = 8;
  localparam int LIVES_W     = 4;
  localparam int COMBO_TIER1 = 10;
  localparam int COMBO_TIER2 = 20;

endpackage : game_pkg
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_keeper_if : lane judgements in, HUD-facing game status out.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface score_keeper_if #(
  parameter int LANES   = 8,
  parameter int SCORE_W = 16,
  parameter int COMBO_W = 9
);
  import game_pkg::*;

  logic                 start;
  logic [LANES-1:0]     hit;
  logic [LANES-1:0]     miss;
  logic [LANES-1:0]     song_over;
  logic [SCORE_W-1:0]   score;
  logic [COMBO_W-1:0]   combo;
  logic [COMBO_W-1:0]   max_combo;
  logic [LIVES_W-1:0]   lives;
  logic                 playing;
  logic                 game_over;

  modport master (
    output start, hit, miss, song_over,
    input  score, combo, max_combo, lives, playing, game_over
  );

  modport slave (
    input  start, hit, miss, song_over,
    output score, combo, max_combo, lives, playing, game_over
  );

endinterface : score_keeper_if
`default_nettype wire

// File: rtl/lane_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lane_popcount : combinational population count of a lane vector.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lane_popcount #(
  parameter int LANES = 8,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  wire logic [LANES-1:0] bits_i,
  output logic      [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < LANES; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule : lane_popcount
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | score_keeper : edge-credits lane hits/misses, keeps score, combo,  |
// | lives and the IDLE/PLAY/OVER session. SCORE_KEEPER_MULT_EN enables |
// | the combo-tier point multiplier.                         Rev 1.0   |
// +--------------------------------------------------------------------+
module score_keeper
  import game_pkg::*;
#(
  parameter int LANES          = NUM_LANES,
  parameter int POINTS_PER_HIT = 10,
  parameter int START_LIVES    = 5,
  parameter int SCORE_W        = 16,
  parameter int COMBO_W        = 9
) (
  input wire logic     Clk,
  input wire logic     reset,
  score_keeper_if.slave bus
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam int ADD_W = SCORE_W + 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  game_state_t          state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic [COMBO_W-1:0]   max_q, max_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LANES-1:0]     hit_q, miss_q;

  logic [LANES-1:0]     hit_rise, miss_rise;
  logic [CNT_W-1:0]     nh, nm;
  logic [ADD_W-1:0]     add_w, sum_w;
  logic [COMBO_W:0]     csum_w;
  logic [SCORE_W-1:0]   score_play;
  logic [COMBO_W-1:0]   combo_play, max_play;
  logic [LIVES_W-1:0]   lives_play;

  assign hit_rise  = bus.hit  & ~hit_q;
  assign miss_rise = bus.miss & ~miss_q;

  lane_popcount #(.LANES(LANES), .CNT_W(CNT_W)) u_pop_hit (
    .bits_i  (hit_rise),
    .count_o (nh)
  );

  lane_popcount #(.LANES(LANES), .CNT_W(CNT_W)) u_pop_miss (
    .bits_i  (miss_rise),
    .count_o (nm)
  );

`ifdef SCORE_KEEPER_MULT_EN
  logic [1:0] pts_shift;

  // Tier comes from the combo before this cycle's hits are added.
  always_comb begin
    if (combo_q < COMBO_W'(COMBO_TIER1))      pts_shift = 2'd0;
    else if (combo_q < COMBO_W'(COMBO_TIER2)) pts_shift = 2'd1;
    else                                      pts_shift = 2'd2;
  end

  assign add_w = (ADD_W'(nh) * ADD_W'(POINTS_PER_HIT)) << pts_shift;
`else
  assign add_w = ADD_W'(nh) * ADD_W'(POINTS_PER_HIT);
`endif

  always_comb begin
    sum_w      = ADD_W'(score_q) + add_w;
    score_play = (sum_w > ADD_W'(SCORE_MAX)) ? SCORE_MAX : sum_w[SCORE_W-1:0];

    // A miss restarts the combo, then this cycle's hits count toward it.
    csum_w     = {1'b0, combo_q} + (COMBO_W + 1)'(nh);
    combo_play = (nm != '0) ? COMBO_W'(nh)
               : (csum_w[COMBO_W] ? {COMBO_W{1'b1}} : csum_w[COMBO_W-1:0]);
    max_play   = (combo_play > max_q) ? combo_play : max_q;
    lives_play = (LIVES_W'(nm) >= lives_q) ? '0 : lives_q - LIVES_W'(nm);
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;
    lives_d = lives_q;
    case (state_q)
      IDLE: ;
      PLAY: begin
        score_d = score_play;
        combo_d = combo_play;
        max_d   = max_play;
        lives_d = lives_play;
        if ((lives_play == '0) || (&bus.song_over)) state_d = OVER;
      end
      OVER: ;
      default: state_d = IDLE;
    endcase
    if (bus.start) begin
      state_d = PLAY;
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
      lives_d = LIVES_INIT;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      lives_q <= LIVES_INIT;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      lives_q <= lives_d;
      hit_q   <= bus.hit;
      miss_q  <= bus.miss;
    end
  end

  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.max_combo = max_q;
  assign bus.lives     = lives_q;
  assign bus.playing   = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);

endmodule : score_keeper
`default_nettype wire
